// File: rtl/vend_seq_ctrl.sv
// Vending transaction sequencer: coin/selection intake, dispense handshake with
// timeout refund, and greedy one-coin-at-a-time change payout.
module vend_seq_ctrl #(
  parameter int PRICE0     = 15,
  parameter int PRICE1     = 25,
  parameter int PRICE2     = 50,
  parameter int PRICE3     = 65,
  parameter int MAX_CREDIT = 200,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [6:0] coin_val,
  output logic       coin_reject,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  output logic       disp_req,
  output logic [1:0] disp_id,
  input  logic       disp_ack,
  output logic       chg_req,
  output logic [6:0] chg_coin,
  input  logic       chg_ack,
  output logic [7:0] credit,
  output logic       add_still,
  output logic       busy,
  output logic       vend_done,
  output logic       fault
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COLLECT  = 2'd1;
  localparam logic [1:0] ST_DISPENSE = 2'd2;
  localparam logic [1:0] ST_CHANGE   = 2'd3;
  localparam int TW = $clog2(TIMEOUT + 1);

  function automatic logic [7:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = 8'(PRICE0);
      2'd1:    price_of = 8'(PRICE1);
      2'd2:    price_of = 8'(PRICE2);
      default: price_of = 8'(PRICE3);
    endcase
  endfunction

  function automatic logic [6:0] pick_coin(input logic [7:0] c);
    if (c >= 8'd50)      pick_coin = 7'd50;
    else if (c >= 8'd20) pick_coin = 7'd20;
    else if (c >= 8'd10) pick_coin = 7'd10;
    else if (c >= 8'd5)  pick_coin = 7'd5;
    else                 pick_coin = 7'd0;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [7:0]    credit_q, credit_d;
  logic [1:0]    disp_id_q, disp_id_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          add_still_q, add_still_d;
  logic          coin_reject_q, coin_reject_d;
  logic          disp_req_q, disp_req_d;
  logic          chg_req_q, chg_req_d;
  logic [6:0]    chg_coin_q, chg_coin_d;
  logic          busy_q, busy_d;
  logic          vend_done_q, vend_done_d;
  logic          fault_q, fault_d;

  logic          coin_legal, coin_ok;
  logic [8:0]    coin_sum;
  logic [7:0]    sel_price;

  assign coin_legal = (coin_val == 7'd5) || (coin_val == 7'd10) ||
                      (coin_val == 7'd20) || (coin_val == 7'd50);
  assign coin_sum   = {1'b0, credit_q} + {2'b0, coin_val};
  assign coin_ok    = coin_legal && (coin_sum <= 9'(MAX_CREDIT));
  assign sel_price  = price_of(sel_id);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_id_d     = disp_id_q;
    tmo_d         = tmo_q;
    add_still_d   = add_still_q;
    coin_reject_d = 1'b0;
    vend_done_d   = 1'b0;
    fault_d       = 1'b0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          if (state_q == ST_COLLECT) begin
            state_d     = ST_CHANGE;
            add_still_d = 1'b0;
          end
        end else if (sel_valid && credit_q >= sel_price) begin
          coin_reject_d = coin_valid;
          credit_d      = credit_q - sel_price;
          disp_id_d     = sel_id;
          tmo_d         = '0;
          add_still_d   = 1'b0;
          state_d       = ST_DISPENSE;
        end else begin
          // A short selection sets add_still even if a coin lands in the same cycle;
          // only a later coin clears it.
          if (sel_valid) add_still_d = 1'b1;
          if (coin_valid) begin
            if (coin_ok) begin
              credit_d = coin_sum[7:0];
              state_d  = ST_COLLECT;
              if (!sel_valid) add_still_d = 1'b0;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end
      ST_DISPENSE: begin
        coin_reject_d = coin_valid;
        if (disp_ack) begin
          if (credit_q != 8'd0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d     = ST_IDLE;
            vend_done_d = 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          credit_d = credit_q + price_of(disp_id_q);
          fault_d  = 1'b1;
          state_d  = ST_CHANGE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        if (chg_ack) begin
          credit_d = credit_q - {1'b0, chg_coin_q};
          if (credit_d == 8'd0) begin
            state_d     = ST_IDLE;
            vend_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state, so a new coin is
    // presented in the cycle right after each chg_ack.
    disp_req_d = (state_d == ST_DISPENSE);
    chg_req_d  = (state_d == ST_CHANGE);
    busy_d     = disp_req_d || chg_req_d;
    chg_coin_d = chg_req_d ? pick_coin(credit_d) : 7'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      disp_id_q     <= '0;
      tmo_q         <= '0;
      add_still_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      disp_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      chg_coin_q    <= '0;
      busy_q        <= 1'b0;
      vend_done_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_id_q     <= disp_id_d;
      tmo_q         <= tmo_d;
      add_still_q   <= add_still_d;
      coin_reject_q <= coin_reject_d;
      disp_req_q    <= disp_req_d;
      chg_req_q     <= chg_req_d;
      chg_coin_q    <= chg_coin_d;
      busy_q        <= busy_d;
      vend_done_q   <= vend_done_d;
      fault_q       <= fault_d;
    end
  end

  assign coin_reject = coin_reject_q;
  assign disp_req    = disp_req_q;
  assign disp_id     = disp_id_q;
  assign chg_req     = chg_req_q;
  assign chg_coin    = chg_coin_q;
  assign credit      = credit_q;
  assign add_still   = add_still_q;
  assign busy        = busy_q;
  assign vend_done   = vend_done_q;
  assign fault       = fault_q;

endmodule

// File: doc/vend_seq_ctrl.md
# vend_seq_ctrl

Transaction sequencer for the vending machine datapath. Accepts coins and product selections, and tracks credit. Drives the dispenser through a req/ack handshake, then pays out change one coin at a time using the largest denomination first. It is the control layer between the coin/keypad front end and the dispense and change mechanisms.

## Interface

Parameters:
- PRICE0, default 15: price of item 0, in credit units.
- PRICE1, default 25: price of item 1.
- PRICE2, default 50: price of item 2.
- PRICE3, default 65: price of item 3.
- MAX_CREDIT, default 200: credit ceiling. Must be ≤255 and a multiple of 5.
- TIMEOUT, default 16: number of cycles to wait for disp_ack before declaring a fault.

All prices are multiples of 5 and ≤ MAX_CREDIT.

Ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous and active-low.
- coin_valid, in, 1: coin present this cycle.
- coin_val, in, 7: coin value. Accepted values are 5, 10, 20 and 50.
- coin_reject, out, 1: one-cycle pulse when a coin is rejected.
- sel_valid, in, 1: selection strobe.
- sel_id, in, 2: selected item.
- cancel, in, 1: refund request.
- disp_req, out, 1: dispense request.
- disp_id, out, 2: item to dispense. Stable while disp_req is high.
- disp_ack, in, 1: dispenser completed the item.
- chg_req, out, 1: change coin request.
- chg_coin, out, 7: denomination of the requested change coin. Stable while chg_req is high.
- chg_ack, in, 1: change coin ejected.
- credit, out, 8: current credit.
- add_still, out, 1: a selection is pending with insufficient credit.
- busy, out, 1: high in the DISPENSE or CHANGE state.
- vend_done, out, 1: one-cycle pulse when a transaction completes.
- fault, out, 1: one-cycle pulse when the dispenser times out.

## Operation

- States: IDLE, COLLECT, DISPENSE, CHANGE.
- Reset (rst=0 at an edge) gives:
  - state IDLE;
  - credit=0;
  - all outputs 0;
  - timeout counter 0.
- Reset overrides any state, including in the middle of a handshake.
- Coin acceptance is evaluated in IDLE and COLLECT:
  - an illegal value, or a coin that would push credit above MAX_CREDIT, is rejected: coin_reject pulses and credit is unchanged;
  - otherwise credit += coin_val and the state goes to COLLECT.
- Priority in IDLE/COLLECT within one cycle is cancel > sel_valid > coin_valid.
  - A coin arriving alongside a cancel, or alongside a selection that causes a state change, is rejected.
  - A coin arriving alongside an insufficient selection is accepted.
- Cancel:
  - in COLLECT: go to CHANGE;
  - in IDLE: ignored.
- Selection:
  - if credit ≥ PRICE[sel_id]: credit -= price, latch disp_id, go to DISPENSE;
  - otherwise: set add_still, stay in state. add_still clears on the next accepted coin, cancel, or successful selection.
- DISPENSE:
  - disp_req is held high until disp_ack.
  - On disp_ack: go to CHANGE if credit > 0; otherwise go to IDLE and pulse vend_done.
  - If TIMEOUT cycles pass with no ack: credit += price (refund), pulse fault, drop disp_req, go to CHANGE.
- CHANGE:
  - chg_coin = largest of {50, 20, 10, 5} that is ≤ credit; chg_req is high.
  - On chg_ack: credit -= chg_coin. If the new credit is 0, go to IDLE and pulse vend_done; otherwise present the next coin.
  - Credit is always a multiple of 5, so payout always terminates.
- In DISPENSE and CHANGE:
  - every coin_valid is rejected;
  - sel_valid and cancel are ignored.
- Credit never wraps. The MAX_CREDIT check prevents overflow, and subtraction only happens when credit ≥ the subtrahend.

## Timing

- All outputs are registered. An input sampled at edge n is reflected in outputs after edge n, i.e. during cycle n+1.
- Coin to credit update: 1 cycle. coin_reject: a 1-cycle pulse in cycle n+1.
- sel_valid to disp_req high: 1 cycle.
- disp_ack at edge n:
  - disp_req is low in cycle n+1;
  - chg_req is high in cycle n+1 if change is owed.
- Each chg_ack drops chg_req for at least 0 cycles. The next coin is presented in cycle n+1, so chg_req may stay high continuously with chg_coin updating.
- Acks that arrive while the corresponding req is low are ignored.
- Timeout counter:
  - cleared on entry to DISPENSE;
  - fault fires at the edge where the count reaches TIMEOUT;
  - a disp_ack arriving on that same edge wins, and there is no fault.
- vend_done and fault are asserted for exactly one cycle.

## Test plan

- Purchase with change: coins 50 then 20 give credit=70. sel_id=3 → disp_req, disp_id=3. Ack → one chg_coin=5, chg_ack → credit=0, vend_done pulse, IDLE.
- Insufficient credit: coin 50, sel_id=3 → add_still=1, no disp_req. Coin 20 → add_still=0, credit=70.
- Bad and overflow coins:
  - coin_val=7 → coin_reject pulse, credit unchanged;
  - four 50 coins → credit=200; a fifth 50 → rejected, credit=200.
- Cancel refund: credit=85, cancel → change sequence 50, 20, 10, 5 with one ack each → credit=0, vend_done.
- Dispense timeout: credit=20, sel_id=0 (price 15), no ack for 16 cycles → fault pulse, credit=20, single chg_coin=20.
- Reset mid-CHANGE: rst=0 while chg_req is high → next cycle all outputs 0, credit=0, IDLE. Coins are accepted normally after release.
